// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode into a control word and carries it
// through ID/EX, EX/MEM and MEM/WB with load-use interlock, flush and illegal-op flagging.
module pipe_ctrl_unit #(
    parameter int OPC_W     = 4,
    parameter int REG_AW    = 6,
    parameter int INTERLOCK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              illegal_op,
    output logic              ex_valid,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_jump_mem,
    output logic              ex_svpc,
    output logic              ex_gen,
    output logic [1:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_valid,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_regwrt,
    output logic              mem_memtoreg,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    output logic              wb_regwrt,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] wb_rd
);

    logic              d_ill, d_rw, d_m2r, d_mrd, d_mwr, d_asrc;
    logic              d_br, d_jmp, d_jmem, d_svpc, d_gen;
    logic [1:0]        d_op;
    logic              use_rs, use_rt;
    logic [OPC_W-1:0]  opc_hi;

    // EX-stage controls that feed only the next stage and the hazard check
    logic              ex_mem_read, ex_mem_write, ex_regwrt, ex_memtoreg;

    logic              hazard, load;

    assign opc_hi = id_opcode >> 4;

    always_comb begin
        d_ill  = 1'b0;
        d_rw   = 1'b0;
        d_m2r  = 1'b0;
        d_mrd  = 1'b0;
        d_mwr  = 1'b0;
        d_asrc = 1'b0;
        d_br   = 1'b0;
        d_jmp  = 1'b0;
        d_jmem = 1'b0;
        d_svpc = 1'b0;
        d_gen  = 1'b0;
        d_op   = 2'b00;
        use_rs = 1'b0;
        use_rt = 1'b0;
        if (|opc_hi) begin
            d_ill = 1'b1;
        end else begin
            case (id_opcode[3:0])
                4'b0000: ;
                4'b1111: begin d_rw = 1'b1; d_svpc = 1'b1; d_gen = 1'b1; end
                4'b1110: begin
                    d_rw = 1'b1; d_m2r = 1'b1; d_mrd = 1'b1; d_asrc = 1'b1; use_rs = 1'b1;
                end
                4'b0011: begin d_mwr = 1'b1; d_asrc = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                4'b0100: begin d_rw = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                4'b0101: begin d_rw = 1'b1; d_asrc = 1'b1; d_op = 2'b10; use_rs = 1'b1; end
                4'b0110: begin d_rw = 1'b1; d_asrc = 1'b1; d_op = 2'b11; use_rs = 1'b1; end
                4'b0111: begin d_rw = 1'b1; d_op = 2'b01; use_rs = 1'b1; use_rt = 1'b1; end
                4'b1000: begin d_jmp = 1'b1; use_rs = 1'b1; end
                4'b1001: begin d_br = 1'b1; use_rs = 1'b1; end
                4'b1010: begin d_mrd = 1'b1; d_jmp = 1'b1; d_jmem = 1'b1; use_rs = 1'b1; end
                4'b1011: begin d_br = 1'b1; use_rs = 1'b1; end
                default: d_ill = 1'b1;
            endcase
        end
    end

    // JM reads memory for its target, not for a register, so it never interlocks
    assign hazard = (INTERLOCK != 0) & id_valid & ex_valid & ex_mem_read & ex_regwrt & ~ex_jump_mem
                  & ((use_rs & (id_rs == ex_rd)) | (use_rt & (id_rt == ex_rd)));

    assign stall = hazard & ~flush & ~rst;
    assign load  = id_valid & ~d_ill & ~flush & ~hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op   <= 1'b0;
            ex_valid     <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_jump_mem  <= 1'b0;
            ex_svpc      <= 1'b0;
            ex_gen       <= 1'b0;
            ex_alu_op    <= 2'b00;
            ex_rd        <= '0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_regwrt    <= 1'b0;
            ex_memtoreg  <= 1'b0;
            mem_valid    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_regwrt   <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrt    <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            illegal_op   <= id_valid & d_ill & ~flush;
            ex_valid     <= load;
            ex_alu_src   <= load & d_asrc;
            ex_branch    <= load & d_br;
            ex_jump      <= load & d_jmp;
            ex_jump_mem  <= load & d_jmem;
            ex_svpc      <= load & d_svpc;
            ex_gen       <= load & d_gen;
            ex_alu_op    <= load ? d_op : 2'b00;
            ex_rd        <= (load & d_rw) ? id_rd : '0;
            ex_mem_read  <= load & d_mrd;
            ex_mem_write <= load & d_mwr;
            ex_regwrt    <= load & d_rw;
            ex_memtoreg  <= load & d_m2r;
            mem_valid    <= ex_valid;
            mem_read     <= ex_mem_read;
            mem_write    <= ex_mem_write;
            mem_regwrt   <= ex_regwrt;
            mem_memtoreg <= ex_memtoreg;
            mem_rd       <= ex_rd;
            wb_valid     <= mem_valid;
            wb_regwrt    <= mem_regwrt;
            wb_memtoreg  <= mem_memtoreg;
            wb_rd        <= mem_rd;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected stage words are queued at drive time
// and compared after the clock edge; a second INTERLOCK=0 instance must never stall.
module tb_pipe_ctrl_unit;

    logic       clk, rst;
    logic       id_valid, flush;
    logic [5:0] id_opcode;
    logic [3:0] n_opcode;
    logic [5:0] id_rs, id_rt, id_rd;

    logic       stall, illegal_op;
    logic       ex_valid, ex_alu_src, ex_branch, ex_jump, ex_jump_mem, ex_svpc, ex_gen;
    logic [1:0] ex_alu_op;
    logic [5:0] ex_rd, mem_rd, wb_rd;
    logic       mem_valid, mem_read, mem_write, mem_regwrt, mem_memtoreg;
    logic       wb_valid, wb_regwrt, wb_memtoreg;

    logic       n_stall, n_illegal_op;
    logic       n_ex_valid, n_ex_alu_src, n_ex_branch, n_ex_jump, n_ex_jump_mem, n_ex_svpc, n_ex_gen;
    logic [1:0] n_ex_alu_op;
    logic [5:0] n_ex_rd, n_mem_rd, n_wb_rd;
    logic       n_mem_valid, n_mem_read, n_mem_write, n_mem_regwrt, n_mem_memtoreg;
    logic       n_wb_valid, n_wb_regwrt, n_wb_memtoreg;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_unit #(.OPC_W(6), .REG_AW(6), .INTERLOCK(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall), .illegal_op(illegal_op),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_jump_mem(ex_jump_mem), .ex_svpc(ex_svpc), .ex_gen(ex_gen), .ex_alu_op(ex_alu_op),
        .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_regwrt(mem_regwrt), .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_regwrt(wb_regwrt), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
    );

    pipe_ctrl_unit #(.OPC_W(4), .REG_AW(6), .INTERLOCK(0)) dut_ni (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(n_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(n_stall), .illegal_op(n_illegal_op),
        .ex_valid(n_ex_valid), .ex_alu_src(n_ex_alu_src), .ex_branch(n_ex_branch), .ex_jump(n_ex_jump),
        .ex_jump_mem(n_ex_jump_mem), .ex_svpc(n_ex_svpc), .ex_gen(n_ex_gen), .ex_alu_op(n_ex_alu_op),
        .ex_rd(n_ex_rd), .mem_valid(n_mem_valid), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .mem_regwrt(n_mem_regwrt), .mem_memtoreg(n_mem_memtoreg), .mem_rd(n_mem_rd),
        .wb_valid(n_wb_valid), .wb_regwrt(n_wb_regwrt), .wb_memtoreg(n_wb_memtoreg), .wb_rd(n_wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v, asrc, br, jmp, jmem, svpc, gen;
        logic [1:0] op;
        logic [5:0] dst;
        logic       mrd, mwr, rw, m2r, ill;
    } ctl_t;

    typedef struct packed {
        ctl_t ex;
        ctl_t mem;
        ctl_t wb;
    } rec_t;

    ctl_t m_ex, m_mem, m_wb;
    rec_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t dec(input logic [5:0] opc, input logic [5:0] rd);
        ctl_t c;
        c = '0;
        if (opc[5:4] != 2'b00) begin
            c.ill = 1'b1;
        end else begin
            case (opc[3:0])
                4'h0: ;
                4'hF: begin c.rw = 1; c.svpc = 1; c.gen = 1; end
                4'hE: begin c.rw = 1; c.m2r = 1; c.mrd = 1; c.asrc = 1; end
                4'h3: begin c.mwr = 1; c.asrc = 1; end
                4'h4: c.rw = 1;
                4'h5: begin c.rw = 1; c.asrc = 1; c.op = 2'b10; end
                4'h6: begin c.rw = 1; c.asrc = 1; c.op = 2'b11; end
                4'h7: begin c.rw = 1; c.op = 2'b01; end
                4'h8: c.jmp = 1;
                4'h9: c.br = 1;
                4'hA: begin c.mrd = 1; c.jmp = 1; c.jmem = 1; end
                4'hB: c.br = 1;
                default: c.ill = 1'b1;
            endcase
        end
        c.v   = ~c.ill;
        c.dst = c.rw ? rd : 6'd0;
        return c;
    endfunction

    task automatic step(input logic v, input logic [5:0] opc, input logic [5:0] rs,
                        input logic [5:0] rt, input logic [5:0] rd, input logic fl,
                        input logic exp_stall);
        ctl_t nw;
        rec_t r;
        id_valid  = v;
        id_opcode = opc;
        n_opcode  = opc[3:0];
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        flush     = fl;
        #2;
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("ni_stall", {31'd0, n_stall}, 32'd0);
        if (!v || fl) nw = '0;
        else if (exp_stall) nw = '0;
        else begin
            nw = dec(opc, rd);
            if (nw.ill) nw = '0;
            nw.ill = dec(opc, rd).ill;
        end
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = nw;
        q.push_back('{ex: m_ex, mem: m_mem, wb: m_wb});
        @(posedge clk);
        #1;
        r = q.pop_front();
        chk("ex_ctl", {23'd0, ex_valid, ex_alu_src, ex_branch, ex_jump, ex_jump_mem, ex_svpc, ex_gen, ex_alu_op},
            {23'd0, r.ex.v, r.ex.asrc, r.ex.br, r.ex.jmp, r.ex.jmem, r.ex.svpc, r.ex.gen, r.ex.op});
        chk("ex_rd", {26'd0, ex_rd}, {26'd0, r.ex.dst});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, r.ex.ill});
        chk("mem_ctl", {27'd0, mem_valid, mem_read, mem_write, mem_regwrt, mem_memtoreg},
            {27'd0, r.mem.v, r.mem.mrd, r.mem.mwr, r.mem.rw, r.mem.m2r});
        chk("mem_rd", {26'd0, mem_rd}, {26'd0, r.mem.dst});
        chk("wb_ctl", {29'd0, wb_valid, wb_regwrt, wb_memtoreg}, {29'd0, r.wb.v, r.wb.rw, r.wb.m2r});
        chk("wb_rd", {26'd0, wb_rd}, {26'd0, r.wb.dst});
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_ex"}, {15'd0, illegal_op, ex_valid, ex_alu_src, ex_branch, ex_jump, ex_jump_mem,
            ex_svpc, ex_gen, ex_alu_op, ex_rd}, 32'd0);
        chk({tag, "_mem"}, {21'd0, mem_valid, mem_read, mem_write, mem_regwrt, mem_memtoreg, mem_rd}, 32'd0);
        chk({tag, "_wb"}, {23'd0, wb_valid, wb_regwrt, wb_memtoreg, wb_rd}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; flush = 0; id_opcode = 0; n_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // back-to-back ALU ops
        step(1, 6'h04, 6'd1, 6'd2, 6'd5, 0, 0);
        step(1, 6'h07, 6'd3, 6'd4, 6'd6, 0, 0);
        step(1, 6'h05, 6'd5, 6'd0, 6'd10, 0, 0);
        step(1, 6'h06, 6'd6, 6'd0, 6'd11, 0, 0);
        nops(3);

        // load-use on rs, then on rt, then ST reading rt
        step(1, 6'h0E, 6'd1, 6'd0, 6'd7, 0, 0);
        step(1, 6'h04, 6'd7, 6'd2, 6'd9, 0, 1);
        step(1, 6'h04, 6'd7, 6'd2, 6'd9, 0, 0);
        nops(3);
        step(1, 6'h0E, 6'd1, 6'd0, 6'd7, 0, 0);
        step(1, 6'h07, 6'd1, 6'd7, 6'd12, 0, 1);
        step(1, 6'h07, 6'd1, 6'd7, 6'd12, 0, 0);
        step(1, 6'h0E, 6'd2, 6'd0, 6'd8, 0, 0);
        step(1, 6'h03, 6'd1, 6'd8, 6'd8, 0, 1);
        step(1, 6'h03, 6'd1, 6'd8, 6'd8, 0, 0);
        nops(3);

        // no-source consumer, INC on other reg, JM in EX with rs matching 0
        step(1, 6'h0E, 6'd1, 6'd0, 6'd7, 0, 0);
        step(1, 6'h0F, 6'd7, 6'd7, 6'd7, 0, 0);
        step(1, 6'h0E, 6'd1, 6'd0, 6'd7, 0, 0);
        step(1, 6'h05, 6'd8, 6'd7, 6'd3, 0, 0);
        step(1, 6'h0A, 6'd4, 6'd0, 6'd0, 0, 0);
        step(1, 6'h04, 6'd0, 6'd0, 6'd1, 0, 0);
        step(1, 6'h0E, 6'd1, 6'd0, 6'd0, 0, 0);
        step(1, 6'h09, 6'd0, 6'd0, 6'd0, 0, 1);
        step(1, 6'h09, 6'd0, 6'd0, 6'd0, 0, 0);
        nops(3);

        // flush overrides a hazard; branch in EX still reaches MEM
        step(1, 6'h0E, 6'd1, 6'd0, 6'd7, 0, 0);
        step(1, 6'h04, 6'd7, 6'd2, 6'd9, 1, 0);
        step(1, 6'h09, 6'd1, 6'd0, 6'd0, 0, 0);
        step(1, 6'h04, 6'd7, 6'd2, 6'd9, 1, 0);
        step(1, 6'h08, 6'd1, 6'd0, 6'd0, 0, 0);
        step(1, 6'h0B, 6'd1, 6'd0, 6'd0, 0, 0);
        nops(3);

        // illegal opcodes, including one killed by flush
        step(1, 6'h0C, 6'd1, 6'd2, 6'd3, 0, 0);
        nops(1);
        step(1, 6'b010100, 6'd1, 6'd2, 6'd3, 0, 0);
        step(1, 6'h01, 6'd1, 6'd2, 6'd3, 0, 0);
        step(1, 6'h0D, 6'd1, 6'd2, 6'd3, 1, 0);
        step(1, 6'h02, 6'd1, 6'd2, 6'd3, 0, 0);
        nops(3);

        // reset in the middle of a stall
        step(1, 6'h0E, 6'd1, 6'd0, 6'd7, 0, 0);
        id_valid = 1; id_opcode = 6'h04; n_opcode = 4'h4; id_rs = 6'd7; id_rt = 6'd2; id_rd = 6'd9;
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk);
        #1;
        chk_all_zero("hold_rst");
        @(negedge clk);
        rst = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        q.delete();
        nops(3);
        step(1, 6'h04, 6'd1, 6'd2, 6'd5, 0, 0);
        nops(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got 0 want 1");
        $fatal(1);
    end

endmodule
